// File: rtl/perceptron_update_engine_if.sv
// -----------------------------------------------------------------------------
// perceptron_update_engine_if
// Update channel of the perceptron branch predictor: one resolved branch per
// accepted handshake.
//   upd_valid   : master offers an update
//   upd_ready   : slave accepts this cycle (valid && ready at a rising edge)
//   upd_index   : perceptron row to train
//   upd_history : global history bits that were used at prediction time
//   upd_sum     : signed dot product y computed at prediction time
//   upd_outcome : resolved direction, 1 = taken
// Modports: master (predictor / retire side), slave (update engine).
// -----------------------------------------------------------------------------
interface perceptron_update_engine_if #(
  parameter int HIST_LEN = 62,
  parameter int IDX_W    = 6,
  parameter int SUM_W    = 16
);
  logic                    upd_valid;
  logic                    upd_ready;
  logic [IDX_W-1:0]        upd_index;
  logic [HIST_LEN-1:0]     upd_history;
  logic signed [SUM_W-1:0] upd_sum;
  logic                    upd_outcome;

  modport master (
    output upd_valid, upd_index, upd_history, upd_sum, upd_outcome,
    input  upd_ready
  );

  modport slave (
    input  upd_valid, upd_index, upd_history, upd_sum, upd_outcome,
    output upd_ready
  );
endinterface

// File: rtl/perceptron_update_engine.sv
// -----------------------------------------------------------------------------
// perceptron_update_engine
// Trains a table of perceptrons (ROWS rows of HIST_LEN+1 signed weights, w0 is
// the bias). An accepted update trains when it mispredicted or when |y| is
// within theta; training walks the row LANES weights per cycle over NBEATS
// cycles, adding +1 where the outcome agrees with the history bit (bias: where
// taken) and -1 otherwise, saturating at the weight range.
//
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   upd          : update channel (perceptron_update_engine_if.slave)
//   rd_index     : predictor read row
//   rd_weights   : registered weights of rd_index, w0 in the low WIDTH bits
//   rd_stale     : registered; the read row was being trained at the sample edge
//   theta        : current training threshold
//   train_pulse  : one-cycle pulse after the last beat of a training run
//   train_count  : saturating count of completed training runs
//
// Optional feature: define PERCEPTRON_ADAPTIVE_THETA_EN to let theta adapt
// through a 7-bit signed mispredict/low-confidence balance counter. Without
// it theta is the constant THETA_INIT.
// -----------------------------------------------------------------------------
module perceptron_update_engine #(
  parameter int HIST_LEN   = 62,
  parameter int WIDTH      = 8,
  parameter int ROWS       = 64,
  parameter int LANES      = 8,
  parameter int SUM_W      = 16,
  parameter int THETA_INIT = 133,
  parameter int IDX_W      = $clog2(ROWS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  perceptron_update_engine_if.slave       upd,
  input  logic [IDX_W-1:0]                rd_index,
  output logic [(HIST_LEN+1)*WIDTH-1:0]   rd_weights,
  output logic                            rd_stale,
  output logic [SUM_W-2:0]                theta,
  output logic                            train_pulse,
  output logic [15:0]                     train_count
);
  localparam int NW     = HIST_LEN + 1;
  localparam int NBEATS = (NW + LANES - 1) / LANES;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int WI_W   = (NW > 1) ? $clog2(NW) : 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_UPDATE = 1'b1;

  localparam logic signed [WIDTH-1:0] W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] W_ONE = 1;
  localparam logic [SUM_W-2:0]        THETA_RST = (SUM_W-1)'(THETA_INIT);

  logic signed [WIDTH-1:0] wt_q [ROWS][NW];

  logic [0:0]          state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [HIST_LEN-1:0] hist_q, hist_d;
  logic                out_q, out_d;
  logic                pulse_q, pulse_d;
  logic [15:0]         count_q, count_d;
  logic [NW*WIDTH-1:0] rd_weights_q, rd_weights_d;
  logic                rd_stale_q, rd_stale_d;

  // Training decision on the offered update.
  logic                accept, mispredict, train;
  logic [SUM_W:0]      sum_ext, abs_sum;

  assign upd.upd_ready = (state_q == S_IDLE);
  assign accept        = upd.upd_valid && (state_q == S_IDLE);
  assign mispredict    = (~upd.upd_sum[SUM_W-1]) != upd.upd_outcome;
  // One extra bit so that |most-negative| is representable.
  assign sum_ext       = {upd.upd_sum[SUM_W-1], upd.upd_sum};
  assign abs_sum       = sum_ext[SUM_W] ? ((SUM_W+1)'(0) - sum_ext) : sum_ext;
  assign train         = mispredict || (abs_sum <= {2'b00, theta});

  // Per-weight direction: bias follows the outcome, wi follows agreement
  // between outcome and history[i-1].
  logic [NW-1:0] inc_vec;
  assign inc_vec = {~(hist_q ^ {HIST_LEN{out_q}}), out_q};

  logic                    lane_en  [LANES];
  logic [WI_W-1:0]         lane_idx [LANES];
  logic signed [WIDTH-1:0] lane_val [LANES];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      // Lanes past the last weight in the final beat stay disabled.
      lane_en[l]  = (state_q == S_UPDATE) && ((int'(beat_q) * LANES + l) < NW);
      lane_idx[l] = lane_en[l] ? WI_W'(int'(beat_q) * LANES + l) : '0;
      lane_val[l] = wt_q[idx_q][lane_idx[l]];
      if (inc_vec[lane_idx[l]]) begin
        if (lane_val[l] != W_MAX) lane_val[l] = lane_val[l] + W_ONE;
      end else begin
        if (lane_val[l] != W_MIN) lane_val[l] = lane_val[l] - W_ONE;
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_d = state_q;
    beat_d  = beat_q;
    idx_d   = idx_q;
    hist_d  = hist_q;
    out_d   = out_q;
    pulse_d = 1'b0;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (accept && train) begin
          state_d = S_UPDATE;
          beat_d  = '0;
          idx_d   = upd.upd_index;
          hist_d  = upd.upd_history;
          out_d   = upd.upd_outcome;
        end
      end
      default: begin
        if (beat_q == BEAT_W'(NBEATS - 1)) begin
          state_d = S_IDLE;
          pulse_d = 1'b1;
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < NW; i++) rd_weights_d[i*WIDTH +: WIDTH] = wt_q[rd_index][i];
    rd_stale_d = (state_q == S_UPDATE) && (rd_index == idx_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the weight table lives in flops rather than RAM because a reset
      // must clear every weight to zero.
      for (int r = 0; r < ROWS; r++)
        for (int i = 0; i < NW; i++)
          wt_q[r][i] <= '0;
      state_q      <= S_IDLE;
      beat_q       <= '0;
      idx_q        <= '0;
      hist_q       <= '0;
      out_q        <= 1'b0;
      pulse_q      <= 1'b0;
      count_q      <= '0;
      rd_weights_q <= '0;
      rd_stale_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make the read capture the pre-write
      // row when a read and a write hit the same row in one cycle.
      for (int l = 0; l < LANES; l++)
        if (lane_en[l]) wt_q[idx_q][lane_idx[l]] <= lane_val[l];
      state_q      <= state_d;
      beat_q       <= beat_d;
      idx_q        <= idx_d;
      hist_q       <= hist_d;
      out_q        <= out_d;
      pulse_q      <= pulse_d;
      count_q      <= count_d;
      rd_weights_q <= rd_weights_d;
      rd_stale_q   <= rd_stale_d;
    end
  end

  assign rd_weights  = rd_weights_q;
  assign rd_stale    = rd_stale_q;
  assign train_pulse = pulse_q;
  assign train_count = count_q;

`ifdef PERCEPTRON_ADAPTIVE_THETA_EN
  localparam logic signed [6:0] TC_ONE = 7'sd1;
  localparam logic signed [6:0] TC_MAX = 7'b011_1111;
  localparam logic signed [6:0] TC_MIN = 7'b100_0000;
  localparam logic [SUM_W-2:0]  THETA_ONE = 1;

  logic signed [6:0] tc_q, tc_d, tc_step;
  logic [SUM_W-2:0]  theta_q, theta_d;

  always_comb begin
    tc_step = tc_q;
    if (accept && mispredict)  tc_step = tc_q + TC_ONE;
    else if (accept && train)  tc_step = tc_q - TC_ONE;
    tc_d    = tc_step;
    theta_d = theta_q;
    // Too many mispredicts: train more eagerly; too many low-confidence
    // correct updates: train less.
    if (tc_step == TC_MAX) begin
      tc_d = '0;
      if (theta_q != '1) theta_d = theta_q + THETA_ONE;
    end else if (tc_step == TC_MIN) begin
      tc_d = '0;
      if (theta_q != '0) theta_d = theta_q - THETA_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tc_q    <= '0;
      theta_q <= THETA_RST;
    end else begin
      tc_q    <= tc_d;
      theta_q <= theta_d;
    end
  end

  assign theta = theta_q;
`else
  assign theta = THETA_RST;
`endif

endmodule

// File: tb/tb_perceptron_update_engine.sv
// -----------------------------------------------------------------------------
// tb_perceptron_update_engine
// Directed scenarios with hand-computed expectations, then randomized traffic.
// A behavioural model (integer weight table advanced LANES weights per cycle
// while a training run is in flight) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_perceptron_update_engine;
  localparam int HIST_LEN   = 62;
  localparam int WIDTH      = 8;
  localparam int ROWS       = 64;
  localparam int LANES      = 8;
  localparam int SUM_W      = 16;
  localparam int THETA_INIT = 133;
  localparam int IDX_W      = $clog2(ROWS);
  localparam int NW         = HIST_LEN + 1;
  localparam int NBEATS     = (NW + LANES - 1) / LANES;
  localparam int WMAX       = 2**(WIDTH-1) - 1;
  localparam int WMIN       = -(2**(WIDTH-1));
  localparam int TMAX       = 2**(SUM_W-1) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  perceptron_update_engine_if #(.HIST_LEN(HIST_LEN), .IDX_W(IDX_W), .SUM_W(SUM_W)) upd ();

  logic [IDX_W-1:0]    rd_index;
  logic [NW*WIDTH-1:0] rd_weights;
  logic                rd_stale;
  logic [SUM_W-2:0]    theta;
  logic                train_pulse;
  logic [15:0]         train_count;

  perceptron_update_engine #(
    .HIST_LEN(HIST_LEN), .WIDTH(WIDTH), .ROWS(ROWS), .LANES(LANES),
    .SUM_W(SUM_W), .THETA_INIT(THETA_INIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd        (upd),
    .rd_index   (rd_index),
    .rd_weights (rd_weights),
    .rd_stale   (rd_stale),
    .theta      (theta),
    .train_pulse(train_pulse),
    .train_count(train_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int                  w [ROWS][NW];
  bit                  m_busy;
  int                  m_row;
  int                  m_beat;
  bit                  m_inc [NW];
  logic [NW*WIDTH-1:0] e_rd;
  bit                  e_stale;
  bit                  e_pulse;
  int                  e_count;
  int                  e_theta;
  int                  m_tc;
  int                  s_m, a_m, wi_m;
  bit                  misp_m, tr_m;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++)
        for (int i = 0; i < NW; i++) w[r][i] = 0;
      m_busy  = 0;
      m_row   = 0;
      m_beat  = 0;
      e_rd    = '0;
      e_stale = 0;
      e_pulse = 0;
      e_count = 0;
      e_theta = THETA_INIT;
      m_tc    = 0;
    end else begin
      // The registered read sees the table as it was before this edge.
      for (int i = 0; i < NW; i++) e_rd[i*WIDTH +: WIDTH] = WIDTH'(w[rd_index][i]);
      e_stale = m_busy && (int'(rd_index) == m_row);
      e_pulse = 0;
      if (m_busy) begin
        for (int l = 0; l < LANES; l++) begin
          wi_m = m_beat * LANES + l;
          if (wi_m < NW) begin
            if (m_inc[wi_m]) w[m_row][wi_m] = (w[m_row][wi_m] < WMAX) ? w[m_row][wi_m] + 1 : WMAX;
            else             w[m_row][wi_m] = (w[m_row][wi_m] > WMIN) ? w[m_row][wi_m] - 1 : WMIN;
          end
        end
        m_beat++;
        if (m_beat == NBEATS) begin
          m_busy  = 0;
          e_pulse = 1;
          if (e_count < 65535) e_count++;
        end
      end else if (upd.upd_valid) begin
        s_m    = int'(upd.upd_sum);
        misp_m = (s_m >= 0) != upd.upd_outcome;
        a_m    = (s_m < 0) ? -s_m : s_m;
        tr_m   = misp_m || (a_m <= e_theta);
        if (tr_m) begin
          m_busy   = 1;
          m_row    = int'(upd.upd_index);
          m_beat   = 0;
          m_inc[0] = upd.upd_outcome;
          for (int i = 1; i < NW; i++) m_inc[i] = (upd.upd_outcome == upd.upd_history[i-1]);
        end
`ifdef PERCEPTRON_ADAPTIVE_THETA_EN
        if (misp_m)    m_tc++;
        else if (tr_m) m_tc--;
        if (m_tc == 63) begin
          if (e_theta < TMAX) e_theta++;
          m_tc = 0;
        end else if (m_tc == -64) begin
          if (e_theta > 0) e_theta--;
          m_tc = 0;
        end
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare against the model
  // ---------------------------------------------------------------------------
  bit cmp_en = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("upd_ready",   upd.upd_ready, !m_busy);
      check("rd_weights",  rd_weights,    e_rd);
      check("rd_stale",    rd_stale,      e_stale);
      check("train_pulse", train_pulse,   e_pulse);
      check("train_count", train_count,   e_count);
      check("theta",       theta,         e_theta);
    end
  end

  int pulse_cnt = 0;
  always @(negedge clk) if (train_pulse) pulse_cnt++;

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at a negedge)
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    upd.upd_valid   = 1'b0;
    upd.upd_index   = '0;
    upd.upd_history = '0;
    upd.upd_sum     = '0;
    upd.upd_outcome = 1'b0;
  endtask

  task automatic offer(input int idx, input logic [HIST_LEN-1:0] hist,
                       input int sum, input bit outcome);
    upd.upd_valid   = 1'b1;
    upd.upd_index   = IDX_W'(idx);
    upd.upd_history = hist;
    upd.upd_sum     = SUM_W'(sum);
    upd.upd_outcome = outcome;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (upd.upd_ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("ready_timeout", 1'b0, 1'b1);
  endtask

  task automatic train_one(input int idx, input logic [HIST_LEN-1:0] hist,
                           input int sum, input bit outcome);
    wait_ready(50);
    offer(idx, hist, sum, outcome);
    @(negedge clk);
    upd.upd_valid = 1'b0;
  endtask

  function automatic logic [HIST_LEN-1:0] rand_hist();
    return HIST_LEN'({$urandom, $urandom});
  endfunction

  function automatic int rand_sum();
    case ($urandom_range(0, 3))
      0: return $urandom_range(0, 300) - 150;
      1: return $urandom_range(0, 1) ? 32767 - $urandom_range(0, 3) : -32768 + $urandom_range(0, 3);
      2: return $urandom_range(0, 1) ? 133 + $urandom_range(0, 1) : -133 - $urandom_range(0, 1);
      default: return int'($signed(16'($urandom)));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  initial begin
    logic [HIST_LEN-1:0] ones;
    ones = '1;
    idle_inputs();
    rd_index = '0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1;

    // Reset state.
    check("rst_ready", upd.upd_ready, 1'b1);
    check("rst_count", train_count, 16'd0);
    check("rst_theta", theta, 15'd133);
    check("rst_rd",    rd_weights, '0);
    check("rst_pulse", train_pulse, 1'b0);

    // Bias and all history weights step to +1 on row 5.
    rd_index = 5;
    offer(5, ones, 0, 1'b1);
    @(negedge clk);
    upd.upd_valid = 1'b0;
    wait_ready(20);
    repeat (2) @(negedge clk);
    check("row5_all_plus1", rd_weights, {NW{8'h01}});
    check("row5_count",     train_count, 16'd1);
    check("row5_pulses",    pulse_cnt, 1);

    // Confident correct updates do not train and keep ready high.
    rd_index = 9;
    offer(9, rand_hist(), 200, 1'b1);
    @(negedge clk);
    check("conf_ready1", upd.upd_ready, 1'b1);
    offer(9, rand_hist(), -250, 1'b0);
    @(negedge clk);
    check("conf_ready2", upd.upd_ready, 1'b1);
    upd.upd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("conf_row9", rd_weights, '0);
    check("conf_pulses", pulse_cnt, 1);

    // Saturation at +127 after 130 trainings.
    rd_index = 3;
    for (int k = 0; k < 130; k++) train_one(3, ones, 0, 1'b1);
    wait_ready(20);
    repeat (2) @(negedge clk);
    check("sat_row3",  rd_weights, {NW{8'h7f}});
    check("sat_count", train_count, 16'd131);

    // Stale read of the row being trained during beat 3, clean read of another.
    wait_ready(20);
    offer(7, rand_hist(), 0, 1'b1);
    @(negedge clk);
    upd.upd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rd_index = 7;
    @(negedge clk);
    check("stale_row7", rd_stale, 1'b1);
    rd_index = 8;
    @(negedge clk);
    check("stale_row8", rd_stale, 1'b0);

    // Reset during beat 4 aborts the run.
    wait_ready(20);
    offer(7, rand_hist(), 0, 1'b1);
    @(negedge clk);
    upd.upd_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_ready", upd.upd_ready, 1'b1);
    check("abort_count", train_count, 16'd0);
    check("abort_pulse", train_pulse, 1'b0);
    pulse_cnt = 0;
    rd_index  = 3;
    @(negedge clk);
    check("abort_row3", rd_weights, '0);
    repeat (12) @(negedge clk);
    check("abort_no_pulse", pulse_cnt, 0);

    // Randomized traffic; rows 0..3 to force read/write collisions.
    for (int c = 0; c < 3000; c++) begin
      rst_n    = ($urandom_range(0, 399) != 0);
      rd_index = $urandom_range(0, 1) ? IDX_W'($urandom_range(0, 3)) : IDX_W'($urandom_range(0, ROWS-1));
      if ($urandom_range(0, 2) != 0) offer($urandom_range(0, 3), rand_hist(), rand_sum(), 1'($urandom_range(0, 1)));
      else                           upd.upd_valid = 1'b0;
      @(negedge clk);
    end
    rst_n = 1'b1;
    upd.upd_valid = 1'b0;

    // Threshold after 63 mispredicts from a clean reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 63; k++) train_one(2, rand_hist(), 5, 1'b0);
    wait_ready(20);
    @(negedge clk);
`ifdef PERCEPTRON_ADAPTIVE_THETA_EN
    check("theta_after_63_misp", theta, 15'd134);
`else
    check("theta_after_63_misp", theta, 15'd133);
`endif
    check("misp_count", train_count, 16'd63);

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/perceptron_update_engine.md
PERCEPTRON_UPDATE_ENGINE -- requirements
Module: perceptron_update_engine

Interface
REQ-001 The block SHALL have parameter HIST_LEN, default 62, meaning global history bits per perceptron.
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning signed weight width.
REQ-003 The block SHALL have parameter ROWS, default 64, meaning perceptron table depth; IDX_W = clog2(ROWS).
REQ-004 The block SHALL have parameter LANES, default 8, meaning weights updated per cycle; NBEATS = ceil((HIST_LEN+1)/LANES).
REQ-005 The block SHALL have parameter SUM_W, default 16, meaning signed dot-product width.
REQ-006 The block SHALL have parameter THETA_INIT, default 133, meaning initial training threshold, floor(1.93*62+14).
REQ-007 The block SHALL use reset rst_n, synchronous, active-low, and clock clk.
REQ-008 The block SHALL have port clk, input, 1, meaning clock.
REQ-009 The block SHALL have port rst_n, input, 1, meaning synchronous active-low reset.
REQ-010 The block SHALL have port upd_valid, input, 1, meaning a resolved-branch update is offered.
REQ-011 The block SHALL have port upd_ready, output, 1, meaning the engine accepts an update this cycle.
REQ-012 The block SHALL have port upd_index, input, IDX_W, meaning the row to train.
REQ-013 The block SHALL have port upd_history, input, HIST_LEN, meaning history bits used at prediction.
REQ-014 The block SHALL have port upd_sum, input, SUM_W signed, meaning the dot product y computed at prediction.
REQ-015 The block SHALL have port upd_outcome, input, 1, meaning 1 = taken.
REQ-016 The block SHALL have port rd_index, input, IDX_W, meaning the predictor read row.
REQ-017 The block SHALL have port rd_weights, output, (HIST_LEN+1)*WIDTH, meaning the weights of rd_index registered; w0 (bias) is in the low WIDTH bits.
REQ-018 The block SHALL have port rd_stale, output, 1, meaning rd_weights came from a row that was mid-update.
REQ-019 The block SHALL have port theta, output, SUM_W-1, meaning the current threshold.
REQ-020 The block SHALL have port train_pulse, output, 1, meaning high for one cycle when a training run completes.
REQ-021 The block SHALL have port train_count, output, 16, meaning a saturating count of completed training runs.

Function
REQ-022 Handshake: an update SHALL be accepted on a rising edge where upd_valid && upd_ready; upd_ready = (state == IDLE).
REQ-023 Predicted direction SHALL be upd_sum >= 0; mispredict = predicted != upd_outcome.
REQ-024 The update SHALL train iff mispredict || |upd_sum| <= theta, with |upd_sum| taken in SUM_W+1 bits so that the most-negative value does not overflow.
REQ-025 A non-training accept SHALL leave the state IDLE, so upd_ready stays high and back-to-back accepts are allowed.
REQ-026 A training accept SHALL latch index/history/outcome, then enter UPDATE for exactly NBEATS cycles, beat b writing weights b*LANES .. b*LANES+LANES-1, after which the state returns to IDLE.
REQ-027 The bias w0 SHALL be incremented if outcome=1, else decremented; wi (i>=1) SHALL be incremented if outcome == history[i-1], else decremented.
REQ-028 Weights SHALL saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and never wrap.
REQ-029 Lanes beyond HIST_LEN in the final beat SHALL be ignored.
REQ-030 train_pulse SHALL assert in the cycle the last beat is written; train_count SHALL increment at the same edge and hold at 0xFFFF.
REQ-031 rd_weights and rd_stale SHALL be registered with one-cycle latency; rd_stale=1 iff state==UPDATE and rd_index==latched index at the sampling edge.
REQ-032 A read and a write to the same row in the same cycle SHALL return the pre-write value.

Reset
REQ-033 When rst_n=0 at an edge, the block SHALL set all weights 0, state IDLE, rd_weights 0, rd_stale 0, train_pulse 0, train_count 0, theta THETA_INIT, and abort any in-flight update; upd_ready SHALL be 1 in the first cycle after reset.

Configuration
REQ-034 Macro PERCEPTRON_ADAPTIVE_THETA_EN: when defined, a 7-bit signed counter tc SHALL increment on each accepted mispredict and decrement on each accepted correct update with |upd_sum| <= theta; at tc==+63 theta SHALL increment (saturating) and tc clear, at tc==-64 theta SHALL decrement (floor 0) and tc clear; when undefined, theta SHALL be constant THETA_INIT and no counter logic SHALL exist.

Verification
REQ-035 After reset, accept index 5, outcome 1, history all-1, upd_sum 0 -> trains; after NBEATS=8 cycles, rd_index 5 gives all 63 weights = +1, train_pulse once, train_count=1.
REQ-036 Accept upd_sum=+200, outcome 1 (correct, confident) -> no training, upd_ready held high, next update accepted the following cycle, weights unchanged.
REQ-037 Drive 130 trainings on row 3 with outcome 1, history all-1 -> every weight saturates at +127, never wraps to -128.
REQ-038 Read row 7 during beat 3 of a training on row 7 -> rd_stale=1; read of row 8 in the same cycle -> rd_stale=0.
REQ-039 Assert rst_n=0 during beat 4 -> the next cycle shows upd_ready=1, all weights 0, train_count 0, and no train_pulse.
REQ-040 With PERCEPTRON_ADAPTIVE_THETA_EN defined, 63 consecutive mispredicts -> theta = 134; without the macro, theta stays 133.
